fft_result_streamer: RTL
========================

FFT_RESULT_STREAMER -- requirements
Module: fft_result_streamer

Interface
REQ-001 SHALL have clock clk, input, 1 bit; every register updates on its rising edge.
REQ-002 SHALL have reset rst, input, 1 bit, asynchronous, active-high.
REQ-003 ena  input  1  global enable; when low, all state holds.
REQ-004 start  input  1  capture request, high for one cycle after the FFT outputs settle.
REQ-005 results_in  input  64  FFT bins; bin k real = [16k+7:16k], bin k imag = [16k+15:16k+8], k=0..3, two's complement.
REQ-006 data_ready  input  1  consumer accepts the current byte.
REQ-007 data_out  output  8  current byte, registered.
REQ-008 data_valid  output  1  data_out holds a byte not yet accepted.
REQ-009 data_oe  output  8  pad output-enable: 8'hFF while in SEND, else 8'h00.
REQ-010 byte_index  output  3  index of the byte on data_out.
REQ-011 busy  output  1  high in SEND and DONE.
REQ-012 frame_done  output  1  one-cycle pulse after the last byte is accepted.
REQ-013 overrun  output  1  sticky flag: start arrived while not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, SEND, DONE; every transition and register update qualified by ena=1.
REQ-015 IDLE, start=1: on that edge, capture results_in into a 64-bit holding register, load data_out with byte 0, set byte_index=0, set data_valid=1, go to SEND; zero added latency.
REQ-016 Byte order without nibble mode: real0, imag0, real1, imag1, real2, imag2, real3, imag3 (byte_index 0..7).
REQ-017 Handshake: a byte is accepted on an edge where data_valid=1, data_ready=1 and ena=1; data_out and byte_index stay stable while data_valid=1 and the byte is not accepted.
REQ-018 Acceptance of a non-final byte: increment byte_index and load the next byte on the same edge; data_valid stays 1, so back-to-back transfers run at one byte per cycle.
REQ-019 Acceptance of the final byte: clear data_valid, go to DONE, and assert frame_done for exactly the following cycle.
REQ-020 DONE: go to IDLE on the next enabled edge; clear frame_done; leave byte_index at 0.
REQ-021 start while in SEND or DONE: ignore it, set overrun=1, leave the holding register and the transfer unaffected.
REQ-022 start and acceptance of the final byte on the same edge: treat as an overrun (start is ignored).
REQ-023 Changes on results_in after capture SHALL NOT affect any byte of the frame.
REQ-024 data_ready while data_valid=0 SHALL have no effect.
REQ-025 ena=0 mid-transfer: freeze the FSM, data_out, byte_index and data_valid; an ena=0 cycle SHALL NOT generate a frame_done pulse.

Reset
REQ-026 rst=1 SHALL immediately force state=IDLE, data_out=8'h00, data_valid=0, data_oe=8'h00, byte_index=0, busy=0, frame_done=0, overrun=0, holding register=0, independent of clk and ena.
REQ-027 Reset asserted mid-frame SHALL abort the frame; no frame_done is produced and the next start begins a fresh frame at byte 0.

Configuration
REQ-028 Macro FFT_STREAM_NIBBLE_EN defined: the frame is 4 bytes, byte k = {real_k[7:4], imag_k[7:4]}, byte_index 0..3, and the final byte is index 3.
REQ-029 Macro FFT_STREAM_NIBBLE_EN undefined: the frame is 8 full-precision bytes per REQ-016, and the final byte is index 7.

Verification
REQ-030 Reset, then start with results_in=64'h0807_0605_0403_0201 and data_ready held 1 -> data_out 01,02,03,04,05,06,07,08 on 8 consecutive cycles, then frame_done=1 for one cycle, then busy=0.
REQ-031 Same frame, data_ready low for 3 cycles at byte_index 2 -> data_out holds 8'h03 with data_valid=1 for those cycles, then the frame resumes without loss.
REQ-032 Start during SEND at byte_index 4 -> overrun=1; remaining bytes 05..08 unchanged; overrun stays 1 until rst.
REQ-033 Change results_in to all-ones after capture -> all frame bytes still match the captured value.
REQ-034 ena=0 for 2 cycles during SEND, then rst pulse at byte_index 5 -> outputs frozen during ena=0; after rst all outputs match REQ-026 and no frame_done occurs.
REQ-035 With FFT_STREAM_NIBBLE_EN, results_in=64'hF0E0_7030_A050_1090 -> bytes 8'h91, 8'h5A, 8'h37, 8'hEF, then frame_done.

Source files
------------

// File: rtl/fft_result_streamer.sv
// Captures four complex FFT bins on start and streams them out a byte at a time over a valid/ready link.
// Define FFT_STREAM_NIBBLE_EN for the 4-byte frame of packed high nibbles; otherwise 8 full-precision bytes.
module fft_result_streamer (
   input  logic        clk,
   input  logic        rst,
   input  logic        ena,
   input  logic        start,
   input  logic [63:0] results_in,
   input  logic        data_ready,
   output logic [7:0]  data_out,
   output logic        data_valid,
   output logic [7:0]  data_oe,
   output logic [2:0]  byte_index,
   output logic        busy,
   output logic        frame_done,
   output logic        overrun
);

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

`ifdef FFT_STREAM_NIBBLE_EN
   localparam logic [2:0] LAST_IDX = 3'd3;

   // Byte k packs the top nibble of real_k above the top nibble of imag_k.
   function automatic logic [7:0] pick_byte(input logic [63:0] v, input logic [2:0] idx);
      logic [15:0] bin;
      bin = v[{idx[1:0], 4'b0000} +: 16];
      return {bin[7:4], bin[15:12]};
   endfunction
`else
   localparam logic [2:0] LAST_IDX = 3'd7;

   // Bins are laid out real-then-imag, so byte order is simply ascending byte lanes.
   function automatic logic [7:0] pick_byte(input logic [63:0] v, input logic [2:0] idx);
      return v[{idx, 3'b000} +: 8];
   endfunction
`endif

   state_t      state;
   logic [63:0] hold;
   logic [2:0]  next_idx;
   logic        accept;

   assign next_idx = byte_index + 3'd1;
   assign accept   = data_valid & data_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         hold       <= 64'h0;
         data_out   <= 8'h00;
         data_valid <= 1'b0;
         data_oe    <= 8'h00;
         byte_index <= 3'd0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
      end else if (ena) begin
         case (state)
            IDLE: begin
               frame_done <= 1'b0;
               if (start) begin
                  hold       <= results_in;
                  data_out   <= pick_byte(results_in, 3'd0);
                  byte_index <= 3'd0;
                  data_valid <= 1'b1;
                  data_oe    <= 8'hFF;
                  busy       <= 1'b1;
                  state      <= SEND;
               end
            end
            SEND: begin
               if (start)
                  overrun <= 1'b1;
               if (accept) begin
                  if (byte_index == LAST_IDX) begin
                     data_valid <= 1'b0;
                     byte_index <= 3'd0;
                     data_oe    <= 8'h00;
                     frame_done <= 1'b1;
                     state      <= DONE;
                  end else begin
                     byte_index <= next_idx;
                     data_out   <= pick_byte(hold, next_idx);
                  end
               end
            end
            DONE: begin
               if (start)
                  overrun <= 1'b1;
               frame_done <= 1'b0;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
